// File: rtl/iterative_alu.sv
// Execute-stage ALU: logic/arithmetic/compare ops finish in one cycle, shifts
// iterate SHIFT_STEP bits per cycle. Valid/ready on both sides, plus flush.
module iterative_alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  busy
);
    localparam int unsigned SW = $clog2(DATA_WIDTH);
    localparam logic [SW:0] STEP_W = (SW + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_e;

    state_e                state_q, state_d;
    kind_e                 kind_q, kind_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [SW-1:0]         cnt_q, cnt_d;

    logic [SW-1:0]         amt;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [SW-1:0]         step;
    logic [DATA_WIDTH-1:0] shifted;

    assign amt      = src_b[SW-1:0];
    assign is_shift = (operation == 4'b0100) || (operation == 4'b0101) || (operation == 4'b0111);

    // Single-cycle result; a shift only lands here with amount 0, i.e. src_a unchanged.
    always_comb begin
        alu_res = '0;
        case (operation)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a ^ src_b;
            4'b0100, 4'b0101, 4'b0111: alu_res = src_a;
            4'b0110: alu_res = src_a - src_b;
            4'b1000: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a == src_b};
            4'b1001: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b1010: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) >= $signed(src_b)};
            4'b1011: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a != src_b};
            4'b1100: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b1101: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
            default: alu_res = '0;
        endcase
    end

    // The step never exceeds what remains, so it always fits in SW bits.
    assign step = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SW-1:0];

    always_comb begin
        case (kind_q)
            K_SLL:   shifted = result_q << step;
            K_SRL:   shifted = result_q >> step;
            default: shifted = $unsigned($signed(result_q) >>> step);
        endcase
    end

    // NOTE: every signal driven here gets a default first, otherwise paths that
    // skip an assignment would infer latches.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift && amt != '0) begin
                        result_d = src_a;
                        cnt_d    = amt;
                        case (operation[1:0])
                            2'b00:   kind_d = K_SLL;
                            2'b01:   kind_d = K_SRL;
                            default: kind_d = K_SRA;
                        endcase
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - step;
                if (cnt_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over any accept or release in the same cycle.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            kind_q   <= K_SLL;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu: one DUT with SHIFT_STEP=1,
// one with SHIFT_STEP=4 sharing clock, reset and operand buses.
module tb_iterative_alu;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [3:0]  operation;
    logic [31:0] src_a, src_b;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    logic        flush4, in_valid4, out_ready4;
    logic        in_ready4, out_valid4, zero4, busy4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .operation(operation), .src_a(src_a), .src_b(src_b), .out_valid(out_valid4),
        .out_ready(out_ready4), .result(result4), .zero(zero4), .busy(busy4)
    );

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op; src_a = a; src_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || zero !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b zero=%b result=%h, required 1 0 0 1 00000000",
                     in_ready, out_valid, busy, zero, result);
        end
    endtask

    task automatic test_single_cycle();
        vec_t v[$];
        v.push_back('{4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234}); // AND
        v.push_back('{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F}); // OR
        v.push_back('{4'b0010, 32'd5,         32'd7,         32'd12});        // ADD
        v.push_back('{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'h0});         // ADD wrap
        v.push_back('{4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555}); // XOR
        v.push_back('{4'b0110, 32'd3,         32'd5,         32'hFFFF_FFFE}); // SUB
        v.push_back('{4'b1000, 32'd4,         32'd4,         32'd1});         // BEQ
        v.push_back('{4'b1000, 32'd4,         32'd5,         32'd0});         // BEQ
        v.push_back('{4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd1});         // BLT
        v.push_back('{4'b1010, 32'hFFFF_FFFF, 32'd1,         32'd0});         // BGE
        v.push_back('{4'b1010, 32'd5,         32'd5,         32'd1});         // BGE equal
        v.push_back('{4'b1011, 32'd4,         32'd5,         32'd1});         // BNE
        v.push_back('{4'b1100, 32'h8000_0000, 32'd0,         32'd1});         // SLT
        v.push_back('{4'b1101, 32'h8000_0000, 32'd0,         32'd0});         // SLTU
        v.push_back('{4'b1101, 32'd1,         32'd2,         32'd1});         // SLTU
        v.push_back('{4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0});         // reserved
        v.push_back('{4'b1111, 32'h1234_5678, 32'd1,         32'd0});         // reserved
        v.push_back('{4'b0100, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234}); // SLL by 0
        v.push_back('{4'b0111, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001}); // SRA by 0
        foreach (v[i]) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            issue(v[i].op, v[i].a, v[i].b);
            checks++;
            if (out_valid !== 1'b1 || result !== v[i].exp || zero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL single_op[%0d] op=%b: out_valid=%b result=%h zero=%b, required 1 %h %b",
                         i, v[i].op, out_valid, result, zero, v[i].exp, v[i].exp == 32'h0);
            end
            release_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_release[%0d]: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_sra_step1();
        int cycles;
        issue(4'b0111, 32'h8000_0000, 32'd31);
        src_a = 32'h0; src_b = 32'h0; operation = 4'b0000; // must not disturb the shift
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sra_busy: busy=%b out_valid=%b in_ready=%b, required 1 0 0", busy, out_valid, in_ready);
        end
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 32 || result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sra_latency: cycles=%0d result=%h, required 32 ffffffff", cycles, result);
        end
        release_result();
    endtask

    task automatic test_step4();
        vec_t v[$];
        int   lat[$];
        int   cycles;
        v.push_back('{4'b0101, 32'hF000_0000, 32'd6,  32'h03C0_0000}); lat.push_back(3); // SRL 4+2
        v.push_back('{4'b0111, 32'h8000_0000, 32'd5,  32'hFC00_0000}); lat.push_back(3); // SRA 4+1
        v.push_back('{4'b0100, 32'h0000_0001, 32'd31, 32'h8000_0000}); lat.push_back(9); // SLL 7x4+3
        v.push_back('{4'b0101, 32'h8000_0000, 32'd4,  32'h0800_0000}); lat.push_back(2); // exact step
        foreach (v[i]) begin
            operation = v[i].op; src_a = v[i].a; src_b = v[i].b; in_valid4 = 1'b1;
            @(negedge clk);
            in_valid4 = 1'b0;
            cycles = 1;
            while (out_valid4 !== 1'b1 && cycles < 100) begin
                @(negedge clk);
                cycles++;
            end
            checks++;
            if (cycles != lat[i] || result4 !== v[i].exp || zero4 !== 1'b0) begin
                errors++;
                $display("FAIL step4_shift[%0d]: cycles=%0d result=%h zero=%b, required %0d %h 0",
                         i, cycles, result4, zero4, lat[i], v[i].exp);
            end
            out_ready4 = 1'b1;
            @(negedge clk);
            out_ready4 = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        issue(4'b0010, 32'd1, 32'd2);
        in_valid = 1'b1; operation = 4'b0010; src_a = 32'd100; src_b = 32'd100;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b result=%h in_ready=%b busy=%b, required 1 00000003 0 1",
                         i, out_valid, result, in_ready, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_flush();
        issue(4'b0100, 32'h0000_0001, 32'd20);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_shift: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_valid[%0d]: out_valid=%b, required 0", i, out_valid);
            end
        end
        // flush beats a simultaneous in_valid
        flush = 1'b1;
        issue(4'b0010, 32'd9, 32'd9);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_accept: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        issue(4'b0010, 32'd10, 32'd20);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd30) begin
            errors++;
            $display("FAIL flush_then_add: out_valid=%b result=%h, required 1 0000001e", out_valid, result);
        end
        // flush in DONE discards the result even with out_ready high
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        issue(4'b0010, 32'd2, 32'd3);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            errors++;
            $display("FAIL reset_mid_setup: out_valid=%b result=%h, required 1 00000005", out_valid, result);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b result=%h zero=%b busy=%b in_ready=%b, required 0 00000000 1 0 1",
                     out_valid, result, zero, busy, in_ready);
        end
        // reset during a shift
        issue(4'b0101, 32'hFFFF_FFFF, 32'd10);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || result !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_shift: busy=%b result=%h out_valid=%b, required 0 00000000 0", busy, result, out_valid);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        operation = 4'b0000; src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_single_cycle();
        test_sra_step1();
        test_step4();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
